// File: rtl/apb4_bridge_mux_pkg.sv
// Shared types for the APB4 bridge: FSM state encoding and PPROT bit constants.
package apb4_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_t;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

endpackage

// File: rtl/apb4_bridge_mux_if.sv
// CPU request/response channel plus APB4 completer-side bus of the bridge.
interface apb4_bridge_mux_if
  import apb4_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [DATA_W-1:0]         req_wdata;
  logic [STRB_W-1:0]         req_strb;
  logic [2:0]                req_prot;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic [2:0]                PPROT;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  // Bridge side: accepts CPU requests and drives the APB requester signals.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

endinterface

// File: rtl/apb4_bridge_mux_decode.sv
// Combinational window/completer decode: upper address bits -> hit, index, one-hot select.
module apb_addr_decode
  import apb4_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter int                SLV_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic [ADDR_W-1:SLV_AW]     i_addr_hi,
  output logic                       o_hit,
  output logic [$clog2(NUM_SLV)-1:0] o_idx,
  output logic [NUM_SLV-1:0]         o_onehot
);
  localparam int IDX_W = $clog2(NUM_SLV);
  localparam int TOP   = SLV_AW + IDX_W;

  assign o_hit    = (i_addr_hi[ADDR_W-1:TOP] == BASE_ADDR[ADDR_W-1:TOP]);
  assign o_idx    = i_addr_hi[SLV_AW +: IDX_W];
  assign o_onehot = NUM_SLV'(1) << o_idx;

endmodule

// File: rtl/apb4_bridge_mux.sv
// APB4 requester bridge: valid/ready CPU request -> SETUP/ACCESS transfer to one of
// NUM_SLV completers, with decode-error path, ACCESS timeout and registered response.
module apb4_bridge_mux
  import apb4_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter int                SLV_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int                TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  apb4_bridge_mux_if.master bus
);
  localparam int IDX_W  = $clog2(NUM_SLV);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              r_state, w_next;
  logic                r_req_ready;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [2:0]          r_pprot;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_SLV-1:0]  r_sel_oh;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_accept;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic [NUM_SLV-1:0]  w_onehot;
  logic                w_pready;
  logic                w_pslverr;
  logic [DATA_W-1:0]   w_prdata;
  logic                w_done;
  logic                w_expire;

  apb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_SLV  (NUM_SLV),
    .SLV_AW   (SLV_AW),
    .BASE_ADDR(BASE_ADDR)
  ) u_dec (
    .i_addr_hi(bus.req_addr[ADDR_W-1:SLV_AW]),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_accept = bus.req_valid & r_req_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_done    = 1'b0;
    w_expire  = 1'b0;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    // Only the latched completer's response lines are ever looked at.
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_pready  = bus.PREADY[i];
        w_pslverr = bus.PSLVERR[i];
        w_prdata  = bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
    case (r_state)
      IDLE:   if (w_accept) w_next = w_hit ? SETUP : DERR;
      SETUP:  w_next = ACCESS;
      ACCESS: begin
        if (w_pready) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_next   = IDLE;
          w_expire = 1'b1;
        end
      end
      DERR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, timeout counter and one-cycle response register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req_ready <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_idx       <= '0;
      r_sel_oh    <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_req_ready <= (w_next == IDLE);
      if (w_accept) begin
        r_paddr  <= bus.req_addr;
        r_pwrite <= bus.req_write;
        r_pwdata <= bus.req_wdata;
        r_pstrb  <= bus.req_write ? bus.req_strb : '0;
        r_pprot  <= bus.req_prot;
        r_idx    <= w_idx;
        r_sel_oh <= w_onehot;
      end
      r_cnt       <= ((r_state == ACCESS) && (w_next == ACCESS)) ? r_cnt + CNT_W'(1) : '0;
      r_rsp_valid <= w_done | w_expire | (r_state == DERR);
      r_rsp_err   <= (r_state == DERR) | w_expire | (w_done & w_pslverr);
      r_rsp_rdata <= (w_done & ~w_pslverr & ~r_pwrite) ? w_prdata : '0;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.PSEL      = ((r_state == SETUP) || (r_state == ACCESS)) ? r_sel_oh : '0;
  assign bus.PENABLE   = (r_state == ACCESS);
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSTRB     = r_pstrb;
  assign bus.PPROT     = r_pprot;

endmodule

// File: tb/tb_apb4_bridge_mux.sv
// Directed bench for apb4_bridge_mux: write, waited read, decode miss, timeout,
// completer error / foreign-completer isolation, async reset abort.
module tb_apb4_bridge_mux;
  import apb4_bridge_pkg::*;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  apb4_bridge_mux_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

  apb4_bridge_mux #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_AW(12),
    .BASE_ADDR(32'h4000_0000), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    bus.req_prot  = prot;
  endtask

  int  en_cnt;
  bit  seen_rsp;

  initial begin
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    bus.PRDATA    = {32'h1234_5678, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   64'(bus.req_ready), 64'd0);
    check("rst_psel",    64'(bus.PSEL),      64'd0);
    check("rst_penable", 64'(bus.PENABLE),   64'd0);
    check("rst_rsp",     64'(bus.rsp_valid), 64'd0);
    check("rst_paddr",   64'(bus.PADDR),     64'd0);
    @(negedge clk) resetn = 1'b1;
    tick();
    check("rst_rel_ready", 64'(bus.req_ready), 64'd1);

    // Zero-wait write to completer 1
    bus.PREADY = 4'b0010;
    request(1'b1, 32'h4000_1004, 32'hDEAD_BEEF, 4'hF, PPROT_PRIV | PPROT_NONSEC);
    tick();
    bus.req_valid = 1'b0;
    check("wr_setup_psel",    64'(bus.PSEL),      64'h2);
    check("wr_setup_penable", 64'(bus.PENABLE),   64'd0);
    check("wr_ready_busy",    64'(bus.req_ready), 64'd0);
    check("wr_paddr",         64'(bus.PADDR),     64'h4000_1004);
    check("wr_pwdata",        64'(bus.PWDATA),    64'hDEAD_BEEF);
    check("wr_pstrb",         64'(bus.PSTRB),     64'hF);
    check("wr_pwrite",        64'(bus.PWRITE),    64'd1);
    check("wr_pprot",         64'(bus.PPROT),     64'h3);
    tick();
    check("wr_access_psel",    64'(bus.PSEL),      64'h2);
    check("wr_access_penable", 64'(bus.PENABLE),   64'd1);
    check("wr_access_rsp",     64'(bus.rsp_valid), 64'd0);
    tick();
    check("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("wr_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("wr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("wr_done_psel", 64'(bus.PSEL),      64'd0);
    check("wr_rsp_ready", 64'(bus.req_ready), 64'd1);

    // Read from completer 3, issued in the response cycle, 3 wait states
    request(1'b0, 32'h4000_3000, 32'h0, 4'hF, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    check("rd_b2b_rsp_clr", 64'(bus.rsp_valid), 64'd0);
    check("rd_setup_psel",  64'(bus.PSEL),      64'h8);
    check("rd_pstrb",       64'(bus.PSTRB),     64'h0);
    check("rd_pwrite",      64'(bus.PWRITE),    64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_wait_penable", 64'(bus.PENABLE),   64'd1);
      check("rd_wait_rsp",     64'(bus.rsp_valid), 64'd0);
    end
    bus.PREADY = 4'b1010;
    tick();
    check("rd_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rd_rsp_rdata", 64'(bus.rsp_rdata), 64'h1234_5678);
    check("rd_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rd_done_psel", 64'(bus.PSEL),      64'd0);
    bus.PREADY = 4'b0000;
    tick();
    check("rd_rsp_pulse", 64'(bus.rsp_valid), 64'd0);

    // Decode miss
    request(1'b0, 32'h5000_0000, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    check("derr_psel",    64'(bus.PSEL),      64'd0);
    check("derr_penable", 64'(bus.PENABLE),   64'd0);
    check("derr_rsp_early", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("derr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("derr_rsp_err",   64'(bus.rsp_err),   64'd1);
    check("derr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("derr_psel2",     64'(bus.PSEL),      64'd0);
    tick();

    // Completer 2 never ready: ACCESS timeout
    request(1'b0, 32'h4000_2000, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    check("to_setup_psel", 64'(bus.PSEL), 64'h4);
    en_cnt   = 0;
    seen_rsp = 1'b0;
    for (int i = 0; i < 40 && !seen_rsp; i++) begin
      tick();
      if (bus.PENABLE) en_cnt++;
      if (bus.rsp_valid) begin
        seen_rsp = 1'b1;
        check("to_rsp_err",     64'(bus.rsp_err),   64'd1);
        check("to_rsp_rdata",   64'(bus.rsp_rdata), 64'd0);
        check("to_end_penable", 64'(bus.PENABLE),   64'd0);
        check("to_end_psel",    64'(bus.PSEL),      64'd0);
      end
    end
    check("to_rsp_seen",       64'(seen_rsp), 64'd1);
    check("to_penable_cycles", 64'(en_cnt),   64'd16);
    tick();

    // Completer 0 PSLVERR with PREADY, other completers asserting error
    bus.PREADY  = 4'b1111;
    bus.PSLVERR = 4'b1111;
    request(1'b1, 32'h4000_0000, 32'h0000_0001, 4'h1, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    check("err_setup_psel", 64'(bus.PSEL), 64'h1);
    tick();
    check("err_access_penable", 64'(bus.PENABLE), 64'd1);
    tick();
    check("err_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("err_rsp_err",   64'(bus.rsp_err),   64'd1);
    tick();

    // Completer 0 read; foreign PREADY/PSLVERR must not complete it
    bus.PREADY  = 4'b1110;
    bus.PSLVERR = 4'b1110;
    bus.PRDATA[0 +: 32] = 32'hA5A5_0000;
    request(1'b0, 32'h4000_0010, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("iso_access_penable", 64'(bus.PENABLE), 64'd1);
    bus.PREADY = 4'b0110;
    tick();
    check("iso_still_waiting", 64'(bus.PENABLE),   64'd1);
    check("iso_no_rsp",        64'(bus.rsp_valid), 64'd0);
    bus.PREADY = 4'b1111;
    tick();
    check("iso_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("iso_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("iso_rsp_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0000);
    bus.PREADY  = 4'b0000;
    bus.PSLVERR = 4'b0000;
    tick();

    // Async reset during ACCESS
    request(1'b1, 32'h4000_2000, 32'h1111_2222, 4'hF, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("ar_access_penable", 64'(bus.PENABLE), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("ar_psel",    64'(bus.PSEL),      64'd0);
    check("ar_penable", 64'(bus.PENABLE),   64'd0);
    check("ar_rsp",     64'(bus.rsp_valid), 64'd0);
    check("ar_ready",   64'(bus.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    tick();
    check("ar_rel_ready", 64'(bus.req_ready), 64'd1);
    check("ar_rel_rsp",   64'(bus.rsp_valid), 64'd0);
    bus.PREADY = 4'b0010;
    request(1'b1, 32'h4000_1008, 32'h0BAD_F00D, 4'hF, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    check("ar_rsp_abort_none", 64'(bus.rsp_valid), 64'd0);
    check("ar_new_psel",       64'(bus.PSEL),      64'h2);
    check("ar_new_pwdata",     64'(bus.PWDATA),    64'h0BAD_F00D);
    tick();
    check("ar_new_penable", 64'(bus.PENABLE), 64'd1);
    tick();
    check("ar_new_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("ar_new_rsp_err",   64'(bus.rsp_err),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
